// File: rtl/tpu_result_sram_if.sv
// Write, drain-control and host-stream signals of one TPU result bank.
// master = producer/host side, slave = the bank itself.
interface tpu_result_sram_if #(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH        = 6,
    parameter int HOST_DATA_WIDTH   = 32
);
    localparam int ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                       sram_write_enable;
    logic [ADDR_WIDTH-1:0]      sram_waddr;
    logic [ROW_W-1:0]           sram_wdata;
    logic                       drain_start;
    logic [ADDR_WIDTH:0]        drain_len;
    logic                       host_ready;
    logic                       host_valid;
    logic [HOST_DATA_WIDTH-1:0] host_data;
    logic                       host_last;
    logic                       busy;
    logic                       drain_done;
    logic [DEPTH-1:0]           row_written;
    logic                       collision;

    modport master (
        output sram_write_enable, sram_waddr, sram_wdata,
        output drain_start, drain_len, host_ready,
        input  host_valid, host_data, host_last,
        input  busy, drain_done, row_written, collision
    );

    modport slave (
        input  sram_write_enable, sram_waddr, sram_wdata,
        input  drain_start, drain_len, host_ready,
        output host_valid, host_data, host_last,
        output busy, drain_done, row_written, collision
    );
endinterface

// File: rtl/tpu_result_sram.sv
// Row-wide result bank written by one TPU port, drained to the host as HOST_DATA_WIDTH words.
// First host word 3 cycles after drain_start; 2-cycle bubble per row; word held while host_ready=0.
module tpu_result_sram #(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH        = 6,
    parameter int HOST_DATA_WIDTH   = 32
) (
    input logic              clk_i,
    input logic              srst_i,
    tpu_result_sram_if.slave res_if
);
    localparam int ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WPR   = ROW_W / HOST_DATA_WIDTH;
    localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [WW-1:0]       LAST_WORD = WW'(WPR - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LOAD, S_SEND, S_DONE} state_t;

    state_t                state_q;
    logic [ROW_W-1:0]      mem_q [DEPTH];
    logic [ROW_W-1:0]      rd_row_q;
    logic [ROW_W-1:0]      shreg_q;
    logic [ADDR_WIDTH-1:0] row_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [WW-1:0]         word_q;
    logic                  host_valid_q;
    logic                  drain_done_q;
    logic                  collision_q;
    logic [DEPTH-1:0]      row_written_q;

    logic [ADDR_WIDTH:0]   len_d;
    logic                  accept;
    logic                  last_word;
    logic                  last_row;

    assign len_d     = (res_if.drain_len > DEPTH_L) ? DEPTH_L : res_if.drain_len;
    assign accept    = host_valid_q & res_if.host_ready;
    assign last_word = (word_q == LAST_WORD);
    assign last_row  = ({1'b0, row_q} == (len_q - 1'b1));

    // Bank is never reset; the read is registered so a same-edge write is not seen (old data wins).
    always_ff @(posedge clk_i) begin
        if (res_if.sram_write_enable) begin
            mem_q[res_if.sram_waddr] <= res_if.sram_wdata;
        end
        if (state_q == S_RD) begin
            rd_row_q <= mem_q[row_q];
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            row_q         <= '0;
            len_q         <= '0;
            word_q        <= '0;
            host_valid_q  <= 1'b0;
            drain_done_q  <= 1'b0;
            collision_q   <= 1'b0;
            row_written_q <= '0;
        end else begin
            drain_done_q <= 1'b0;
            if (res_if.sram_write_enable) begin
                row_written_q[res_if.sram_waddr] <= 1'b1;
                if (state_q == S_RD && res_if.sram_waddr == row_q) begin
                    collision_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (res_if.drain_start) begin
                        len_q   <= len_d;
                        row_q   <= '0;
                        state_q <= (len_d == '0) ? S_DONE : S_RD;
                    end
                end
                S_RD: state_q <= S_LOAD;
                S_LOAD: begin
                    shreg_q      <= rd_row_q;
                    word_q       <= '0;
                    host_valid_q <= 1'b1;
                    state_q      <= S_SEND;
                end
                S_SEND: begin
                    // The current word always sits in the low bits; shift one word per accept.
                    if (accept) begin
                        shreg_q <= shreg_q >> HOST_DATA_WIDTH;
                        word_q  <= word_q + 1'b1;
                        if (last_word) begin
                            host_valid_q <= 1'b0;
                            if (last_row) begin
                                state_q <= S_DONE;
                            end else begin
                                row_q   <= row_q + 1'b1;
                                state_q <= S_RD;
                            end
                        end
                    end
                end
                S_DONE: begin
                    drain_done_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign res_if.host_valid  = host_valid_q;
    assign res_if.host_data   = shreg_q[HOST_DATA_WIDTH-1:0];
    assign res_if.host_last   = host_valid_q & last_word & last_row;
    assign res_if.busy        = (state_q != S_IDLE);
    assign res_if.drain_done  = drain_done_q;
    assign res_if.row_written = row_written_q;
    assign res_if.collision   = collision_q;
endmodule

// File: tb/tb_tpu_result_sram.sv
// Directed bench for tpu_result_sram: fill, drain with/without stalls, empty drain, collision, reset abort, clamp.
module tb_tpu_result_sram;
    localparam int AS    = 32;
    localparam int ODW   = 16;
    localparam int AW    = 6;
    localparam int HDW   = 32;
    localparam int ROW_W = AS * ODW;
    localparam int DEPTH = 2 ** AW;
    localparam int WPR   = ROW_W / HDW;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    tpu_result_sram_if #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(ODW), .ADDR_WIDTH(AW),
                         .HOST_DATA_WIDTH(HDW)) res_if ();

    tpu_result_sram #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(ODW), .ADDR_WIDTH(AW),
                      .HOST_DATA_WIDTH(HDW)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .res_if (res_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [ROW_W-1:0] model [DEPTH];
    logic [HDW-1:0]   cap_first, cap_16, cap_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Element k of the row is base + k.
    function automatic logic [ROW_W-1:0] mk_row(input int base);
        logic [ROW_W-1:0] r;
        for (int k = 0; k < AS; k++) r[k*ODW +: ODW] = 16'(base + k);
        return r;
    endfunction

    task automatic write_row(input int r, input logic [ROW_W-1:0] d);
        @(negedge clk);
        res_if.sram_write_enable = 1'b1;
        res_if.sram_waddr        = AW'(r);
        res_if.sram_wdata        = d;
        model[r]                 = d;
    endtask

    task automatic write_idle();
        @(negedge clk);
        res_if.sram_write_enable = 1'b0;
    endtask

    // mode 0: host_ready always 1; mode 1: ready on odd cycles only.
    task automatic run_drain(input string tag, input int len, input int exp_rows, input int mode,
                             input int inject_at, input int abort_at, input int restart_at);
        int beats = 0, cyc = 0, first_v = -1, last_cyc = -1, done_cyc = -1, busy_cyc = 0;
        int data_err = 0, last_err = 0, stall_err = 0, done_err = 0;
        bit holding = 0, inj_pending = 0, abort_pending = 0, restarted = 0;
        logic [HDW-1:0] held, exp_w;
        cap_first = '0; cap_16 = '0; cap_last = '0;

        @(negedge clk);
        res_if.drain_start = 1'b1;
        res_if.drain_len   = (AW + 1)'(len);
        res_if.host_ready  = (mode == 0);

        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (abort_pending) begin
                res_if.drain_start       = 1'b0;
                res_if.sram_write_enable = 1'b0;
                srst = 1'b1;
                #1;
                check({tag, "_rst_valid"}, res_if.host_valid, 0);
                check({tag, "_rst_data"}, res_if.host_data, 0);
                check({tag, "_rst_busy"}, res_if.busy, 0);
                check({tag, "_rst_roww"}, res_if.row_written, 0);
                check({tag, "_rst_coll"}, res_if.collision, 0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (res_if.drain_done) done_err++;
                end
                check({tag, "_rst_no_done"}, done_err, 0);
                srst = 1'b0;
                return;
            end
            if (restart_at > 0 && !restarted && beats >= restart_at) begin
                res_if.drain_start = 1'b1;
                restarted = 1;
            end else begin
                res_if.drain_start = 1'b0;
            end
            if (inj_pending) begin
                res_if.sram_write_enable = 1'b1;
                res_if.sram_waddr        = AW'(1);
                res_if.sram_wdata        = mk_row('hA000);
                inj_pending = 0;
            end else begin
                res_if.sram_write_enable = 1'b0;
            end
            res_if.host_ready = (mode == 0) || (cyc % 2 == 1);

            if (res_if.busy) busy_cyc++;
            if (res_if.drain_done) begin
                done_cyc = cyc;
                break;
            end
            if (holding) begin
                if (!res_if.host_valid || res_if.host_data !== held) stall_err++;
                holding = 0;
            end
            if (res_if.host_valid) begin
                if (first_v < 0) first_v = cyc;
                if (beats >= exp_rows * WPR) begin
                    data_err++;
                end else begin
                    exp_w = model[beats / WPR][(beats % WPR) * HDW +: HDW];
                    if (res_if.host_data !== exp_w) data_err++;
                end
                if (res_if.host_last !== (beats == exp_rows * WPR - 1)) last_err++;
                if (res_if.host_ready) begin
                    if (beats == 0)  cap_first = res_if.host_data;
                    if (beats == 16) cap_16    = res_if.host_data;
                    cap_last = res_if.host_data;
                    beats++;
                    last_cyc = cyc;
                    if (inject_at > 0 && beats == inject_at) inj_pending = 1;
                    if (abort_at > 0 && beats == abort_at) abort_pending = 1;
                end else begin
                    holding = 1;
                    held    = res_if.host_data;
                end
            end else if (res_if.host_last) begin
                last_err++;
            end
        end

        res_if.drain_start       = 1'b0;
        res_if.sram_write_enable = 1'b0;
        check({tag, "_beats"}, beats, exp_rows * WPR);
        check({tag, "_data"}, data_err, 0);
        check({tag, "_last"}, last_err, 0);
        check({tag, "_stall"}, stall_err, 0);
        if (exp_rows > 0) begin
            check({tag, "_first_lat"}, first_v, 3);
            check({tag, "_done_cyc"}, done_cyc, last_cyc + 2);
        end else begin
            check({tag, "_no_valid"}, first_v, -1);
            check({tag, "_done_cyc"}, done_cyc, 2);
            check({tag, "_busy_cyc"}, busy_cyc, 1);
        end
        check({tag, "_idle_busy"}, res_if.busy, 0);
    endtask

    initial begin
        srst = 1'b1;
        res_if.sram_write_enable = 1'b0;
        res_if.sram_waddr        = '0;
        res_if.sram_wdata        = '0;
        res_if.drain_start       = 1'b0;
        res_if.drain_len         = '0;
        res_if.host_ready        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", res_if.host_valid, 0);
        check("reset_data", res_if.host_data, 0);
        check("reset_last", res_if.host_last, 0);
        check("reset_busy", res_if.busy, 0);
        check("reset_done", res_if.drain_done, 0);
        check("reset_roww", res_if.row_written, 0);
        check("reset_coll", res_if.collision, 0);
        srst = 1'b0;

        for (int r = 0; r < 4; r++) write_row(r, mk_row(r * 256));
        write_idle();
        check("t1_roww", res_if.row_written, 64'hF);
        check("t1_coll", res_if.collision, 0);

        run_drain("t1", 4, 4, 0, 0, 0, 0);
        check("t1_first_word", cap_first, 32'h0001_0000);
        check("t1_word16", cap_16, 32'h0101_0100);

        run_drain("t2", 4, 4, 1, 0, 0, 0);
        check("t2_word16", cap_16, 32'h0101_0100);

        run_drain("t3", 0, 0, 0, 0, 0, 0);

        run_drain("t4", 4, 4, 0, 16, 0, 0);
        check("t4_old_word16", cap_16, 32'h0101_0100);
        check("t4_coll", res_if.collision, 1);
        model[1] = mk_row('hA000);
        run_drain("t4b", 4, 4, 0, 0, 0, 0);
        check("t4b_new_word16", cap_16, 32'hA001_A000);

        run_drain("t5", 4, 4, 0, 0, 40, 0);
        run_drain("t5b", 4, 4, 0, 0, 0, 0);
        check("t5b_coll", res_if.collision, 0);
        check("t5b_roww", res_if.row_written, 0);

        for (int r = 0; r < DEPTH; r++) write_row(r, mk_row(r * 256));
        write_idle();
        check("t6_roww", res_if.row_written, {64{1'b1}});
        run_drain("t6", 100, 64, 0, 0, 0, 500);
        check("t6_last_word", cap_last, 32'h3F1F_3F1E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
